fsqrt_iter: RTL and testbench

Iterative, parametrised FP32 square-root unit with valid/ready handshakes on both sides, full IEEE special-case handling and round-to-nearest-even. It is the area-lean successor to the table-based pipelined sqrt in the FPU. Root bits come from a digit-recurrence loop that produces BPC bits per cycle, which trades latency against logic. It sits behind the FPU issue logic and raises an invalid-operation flag for the exception path.

---
 rtl/fpu_pkg.sv | 19 +
 rtl/sqrt_rec_step.sv | 19 +
 rtl/fsqrt_iter.sv | 96 +++++++++
 tb/tb_fsqrt_iter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FP32 constants, sqrt FSM states and special-operand helpers.
package fpu_pkg;
  localparam int FP_BIAS = 127;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_PINF = 32'h7F800000;
  localparam int EXP_W = 8;
  localparam int MANT_W = 23;
  typedef enum logic [1:0] {IDLE, SPEC, CALC, DONE} state_t;
  function automatic logic is_special(input logic [31:0] v);
    return v[31] || v[MANT_W +: EXP_W] == '0 || v[MANT_W +: EXP_W] == '1;
  endfunction
  // Returns {invalid, y}; zero/denormal is checked first so -0 and -denormal flush to signed zero.
  function automatic logic [32:0] special_result(input logic [31:0] v);
    if (v[MANT_W +: EXP_W] == '0) return {1'b0, v[31], 31'b0};
    if (v[MANT_W +: EXP_W] == '1 && v[MANT_W-1:0] != '0) return {~v[MANT_W-1], FP_QNAN};
    if (v[MANT_W +: EXP_W] == '1 && !v[31]) return {1'b0, FP_PINF};
    return {1'b1, FP_QNAN};
  endfunction
endpackage

// File: rtl/sqrt_rec_step.sv
// sqrt_rec_step: one restoring square-root recurrence step resolving a single root bit.
module sqrt_rec_step #(
  parameter int N = 26
) (
  input  logic [N+1:0] rem,
  input  logic [N-1:0] root,
  input  logic [1:0]   bits,
  output logic [N+1:0] rem_next,
  output logic         root_bit,
  output logic [N-1:0] root_next
);
  localparam int RW = N + 2;
  logic [N+3:0] cur, trial;
  assign cur = {rem, bits};
  assign trial = {2'b00, root, 2'b01};
  assign root_bit = cur >= trial;
  assign rem_next = root_bit ? RW'(cur - trial) : cur[N+1:0];
  assign root_next = {root[N-2:0], root_bit};
endmodule

// File: rtl/fsqrt_iter.sv
// fsqrt_iter: iterative FP32 square root, BPC root bits per cycle, round-to-nearest-even.
module fsqrt_iter
  import fpu_pkg::*;
#(
  parameter int BPC = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        invalid
);
  localparam int ITER = (25 + BPC - 1) / BPC;
  localparam int N = ITER * BPC;
  localparam int CW = $clog2(ITER + 1);
  state_t state, nxt;
  logic accept, last, carry, guard, sticky;
  logic [31:0] xr, rounded;
  logic [2*N-1:0] xs;
  logic [N+1:0] rem;
  logic [N-1:0] q;
  logic [EXP_W-1:0] ye, ye_in;
  logic [CW-1:0] cnt;
  logic [24:0] rad;
  logic [MANT_W-1:0] mant, mant_r;
  logic [N+1:0] rem_c [BPC+1];
  logic [N-1:0] root_c [BPC+1];
  logic [BPC-1:0] digits_unused;
  assign accept = in_valid && in_ready;
  assign last = cnt == CW'(ITER - 1);
  // Odd exponents keep M, even ones double it so the halved exponent stays exact.
  assign rad = x[MANT_W] ? {2'b01, x[MANT_W-1:0]} : {1'b1, x[MANT_W-1:0], 1'b0};
  assign ye_in = EXP_W'(({1'b0, x[MANT_W +: EXP_W]} + 9'(FP_BIAS) - {8'b0, ~x[MANT_W]}) >> 1);
  assign rem_c[0] = rem;
  assign root_c[0] = q;
  for (genvar i = 0; i < BPC; i++) begin : g_step
    sqrt_rec_step #(.N(N)) u_step (
      .rem(rem_c[i]),
      .root(root_c[i]),
      .bits(xs[2*N-1-2*i -: 2]),
      .rem_next(rem_c[i+1]),
      .root_bit(digits_unused[i]),
      .root_next(root_c[i+1])
    );
  end
  assign mant = root_c[BPC][N-2 -: MANT_W];
  assign guard = root_c[BPC][N-25];
  assign sticky = |(root_c[BPC] & ({N{1'b1}} >> 25)) | |rem_c[BPC];
  assign {carry, mant_r} = {1'b0, mant} + {{MANT_W{1'b0}}, guard & (sticky | mant[0])};
  assign rounded = {1'b0, ye + {{(EXP_W-1){1'b0}}, carry}, mant_r};
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = accept ? (is_special(x) ? SPEC : CALC) :
          state == SPEC ? DONE :
          state == CALC ? (last ? DONE : CALC) :
          state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  always_comb begin
    in_ready = state == IDLE || (state == DONE && out_ready);
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      xr <= '0;
      xs <= '0;
      rem <= '0;
      q <= '0;
      ye <= '0;
      cnt <= '0;
      y <= '0;
      invalid <= 1'b0;
    end else if (accept) begin
      xr <= x;
      xs <= {rad, {(2*N-25){1'b0}}};
      rem <= '0;
      q <= '0;
      ye <= ye_in;
      cnt <= '0;
    end else if (state == SPEC) begin
      {invalid, y} <= special_result(xr);
    end else if (state == CALC) begin
      xs <= xs << (2 * BPC);
      rem <= rem_c[BPC];
      q <= root_c[BPC];
      cnt <= cnt + 1'b1;
      if (last) begin
        y <= rounded;
        invalid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_fsqrt_iter.sv
// tb_fsqrt_iter: directed-vector bench for fsqrt_iter (BPC=2 main instance plus BPC 1/3/8 variants).
module tb_fsqrt_iter;
  logic clk = 1'b0, rstn = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, invalid;
  logic [31:0] x = '0, y;
  logic [2:0] v_valid = '0, v_ready, v_ovalid, v_inv;
  logic [31:0] v_y [3];
  int vectors = 0, errors = 0;
  always #5 clk = ~clk;
  fsqrt_iter #(.BPC(2)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .invalid(invalid)
  );
  for (genvar g = 0; g < 3; g++) begin : g_var
    fsqrt_iter #(.BPC(g == 0 ? 1 : g == 1 ? 3 : 8)) u_v (
      .clk(clk), .rstn(rstn), .in_valid(v_valid[g]), .in_ready(v_ready[g]), .x(x),
      .out_valid(v_ovalid[g]), .out_ready(1'b1), .y(v_y[g]), .invalid(v_inv[g])
    );
  end
  task automatic run_op(input logic [31:0] xv, output logic [31:0] yv, output logic iv, output int lat);
    @(negedge clk);
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    in_valid = 1'b1;
    x = xv;
    @(posedge clk);
    #1 in_valid = 1'b0;
    x = 32'hDEADBEEF;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    yv = y;
    iv = invalid;
  endtask
  task automatic test_reset;
    #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++; if (y !== 32'h0) begin errors++; $display("FAIL reset_y got %h want 00000000", y); end
    vectors++; if (invalid !== 1'b0) begin errors++; $display("FAIL reset_invalid got %b want 0", invalid); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
  endtask
  task automatic test_normal;
    logic [31:0] xin [5] = '{32'h40800000, 32'h40000000, 32'h7F7FFFFF, 32'h41100000, 32'h3F800000};
    logic [31:0] yex [5] = '{32'h40000000, 32'h3FB504F3, 32'h5F7FFFFF, 32'h40400000, 32'h3F800000};
    logic [31:0] yv;
    logic iv;
    int lat;
    for (int k = 0; k < 5; k++) begin
      run_op(xin[k], yv, iv, lat);
      vectors++; if (yv !== yex[k]) begin errors++; $display("FAIL normal_y[%h] got %h want %h", xin[k], yv, yex[k]); end
      vectors++; if (iv !== 1'b0) begin errors++; $display("FAIL normal_invalid[%h] got %b want 0", xin[k], iv); end
      vectors++; if (lat != 14) begin errors++; $display("FAIL normal_latency[%h] got %0d want 14", xin[k], lat); end
    end
  endtask
  task automatic test_special;
    logic [31:0] xin [8] = '{32'h80000000, 32'hBF800000, 32'h7F800000, 32'h7F800001,
                             32'h7FC00001, 32'h00400000, 32'hFF800000, 32'h00000000};
    logic [31:0] yex [8] = '{32'h80000000, 32'h7FC00000, 32'h7F800000, 32'h7FC00000,
                             32'h7FC00000, 32'h00000000, 32'h7FC00000, 32'h00000000};
    logic iex [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] yv;
    logic iv;
    int lat;
    for (int k = 0; k < 8; k++) begin
      run_op(xin[k], yv, iv, lat);
      vectors++; if (yv !== yex[k]) begin errors++; $display("FAIL special_y[%h] got %h want %h", xin[k], yv, yex[k]); end
      vectors++; if (iv !== iex[k]) begin errors++; $display("FAIL special_invalid[%h] got %b want %b", xin[k], iv, iex[k]); end
      vectors++; if (lat != 2) begin errors++; $display("FAIL special_latency[%h] got %0d want 2", xin[k], lat); end
    end
  endtask
  task automatic test_bpc_variants;
    int lex [3] = '{26, 10, 5};
    int lat [3] = '{0, 0, 0};
    logic [31:0] got [3] = '{32'h0, 32'h0, 32'h0};
    logic gi [3] = '{1'b0, 1'b0, 1'b0};
    @(negedge clk);
    vectors++; if (v_ready !== 3'b111) begin errors++; $display("FAIL bpc_in_ready got %b want 111", v_ready); end
    x = 32'h40000000;
    v_valid = 3'b111;
    @(posedge clk);
    #1 v_valid = 3'b000;
    x = 32'h12345678;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++)
        if (v_ovalid[g] && lat[g] == 0) begin
          lat[g] = c;
          got[g] = v_y[g];
          gi[g] = v_inv[g];
        end
    end
    for (int g = 0; g < 3; g++) begin
      vectors++; if (got[g] !== 32'h3FB504F3) begin errors++; $display("FAIL bpc_y[%0d] got %h want 3fb504f3", g, got[g]); end
      vectors++; if (gi[g] !== 1'b0) begin errors++; $display("FAIL bpc_invalid[%0d] got %b want 0", g, gi[g]); end
      vectors++; if (lat[g] != lex[g]) begin errors++; $display("FAIL bpc_latency[%0d] got %0d want %0d", g, lat[g], lex[g]); end
    end
  endtask
  task automatic test_backpressure;
    int lat;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    x = 32'h40800000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    x = 32'hCAFEF00D;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    vectors++; if (lat != 14) begin errors++; $display("FAIL bp_latency got %0d want 14", lat); end
    for (int k = 0; k < 5; k++) begin
      vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d] got %b want 1", k, out_valid); end
      vectors++; if (y !== 32'h40000000) begin errors++; $display("FAIL bp_hold_y[%0d] got %h want 40000000", k, y); end
      vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready[%0d] got %b want 0", k, in_ready); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    x = 32'h41100000;
    #1;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_same_edge_in_ready got %b want 1", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    x = 32'h0BADF00D;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    vectors++; if (y !== 32'h40400000) begin errors++; $display("FAIL bp_next_y got %h want 40400000", y); end
    vectors++; if (lat != 14) begin errors++; $display("FAIL bp_next_latency got %0d want 14", lat); end
  endtask
  task automatic test_reset_mid;
    logic [31:0] yv;
    logic iv, seen;
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    x = 32'h40000000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    vectors++; if (y !== 32'h0) begin errors++; $display("FAIL midrst_y got %h want 00000000", y); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_result got %b want 0", seen); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after got %b want 1", in_ready); end
    run_op(32'h41100000, yv, iv, lat);
    vectors++; if (yv !== 32'h40400000) begin errors++; $display("FAIL midrst_next_y got %h want 40400000", yv); end
    vectors++; if (lat != 14) begin errors++; $display("FAIL midrst_next_latency got %0d want 14", lat); end
  endtask
  initial begin
    test_reset;
    test_normal;
    test_special;
    test_bpc_variants;
    test_backpressure;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
